ahb_out_arb_rr: RTL and testbench

- Round-robin arbiter for one shared-slave output stage of the AHB bus matrix.
- Decides which input port drives the slave address/control phase.
- Consumes the output stage's internal HREADYM, HSELM, HTRANSM, HBURSTM and lock-qualified HMASTLOCKM.
- Produces the registered port index and no-port flag that steer the address and data muxes.
- Preserves AHB atomicity: never re-arbitrates inside a defined-length burst or a locked sequence.

---
 rtl/ahb_out_arb_rr.sv | 112 +++++++++++
 tb/tb_ahb_out_arb_rr.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_out_arb_rr.sv
// rtl/ahb_out_arb_rr.sv - round-robin address-phase arbiter for one AHB matrix output stage
// Define AHB_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module ahb_out_arb_rr #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [IDX_W-1:0]     addr_in_port,
  output logic                 no_port
);

  logic [IDX_W-1:0] addr_in_port_q, addr_in_port_d;
  logic             no_port_q, no_port_d;
  logic [4:0]       beat_cnt_q, beat_cnt_d;
  logic [4:0]       beat_cnt_nxt;
  logic             accept;
  logic             hold;
  logic [IDX_W-1:0] pick;
`ifndef AHB_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] cand;
  logic             found;
`endif

  always_comb begin
    accept       = HREADYM & HSELM & HTRANSM[1];
    beat_cnt_nxt = beat_cnt_q;
    if (accept && HTRANSM == 2'b10) begin
      case (HBURSTM)
        3'b010, 3'b011: beat_cnt_nxt = 5'd3;
        3'b100, 3'b101: beat_cnt_nxt = 5'd7;
        3'b110, 3'b111: beat_cnt_nxt = 5'd15;
        default:        beat_cnt_nxt = 5'd0;
      endcase
    end else if (accept && HTRANSM == 2'b11 && beat_cnt_q != 5'd0) begin
      beat_cnt_nxt = beat_cnt_q - 5'd1;
    end

    // BUSY keeps the port so the slave never sees a burst split mid-flight
    hold = ~no_port_q & (HMASTLOCKM | (beat_cnt_nxt != 5'd0) |
                         (HSELM & (HTRANSM == 2'b01)));

    pick = '0;
`ifdef AHB_ARB_FIXED_PRIO_EN
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_port[i]) pick = IDX_W'(i);
    end
`else
    // Walk upward from the last winner; the last winner itself is visited last
    cand  = last_grant_q;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = (cand == IDX_W'(NUM_PORTS - 1)) ? '0 : cand + IDX_W'(1);
      if (!found && req_port[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
`endif

    addr_in_port_d = addr_in_port_q;
    no_port_d      = no_port_q;
    beat_cnt_d     = beat_cnt_q;
`ifndef AHB_ARB_FIXED_PRIO_EN
    last_grant_d   = last_grant_q;
`endif
    if (HREADYM) begin
      beat_cnt_d = beat_cnt_nxt;
      if (!hold) begin
        if (|req_port) begin
          addr_in_port_d = pick;
          no_port_d      = 1'b0;
`ifndef AHB_ARB_FIXED_PRIO_EN
          last_grant_d   = pick;
`endif
        end else begin
          no_port_d  = 1'b1;
          beat_cnt_d = 5'd0;
        end
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_in_port_q <= '0;
      no_port_q      <= 1'b1;
      beat_cnt_q     <= 5'd0;
`ifndef AHB_ARB_FIXED_PRIO_EN
      last_grant_q   <= IDX_W'(NUM_PORTS - 1);
`endif
    end else begin
      addr_in_port_q <= addr_in_port_d;
      no_port_q      <= no_port_d;
      beat_cnt_q     <= beat_cnt_d;
`ifndef AHB_ARB_FIXED_PRIO_EN
      last_grant_q   <= last_grant_d;
`endif
    end
  end

  assign addr_in_port = addr_in_port_q;
  assign no_port      = no_port_q;

endmodule

// File: tb/tb_ahb_out_arb_rr.sv
// tb/tb_ahb_out_arb_rr.sv - directed self-checking bench for ahb_out_arb_rr
module tb_ahb_out_arb_rr;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] req_port;
  logic       HREADYM;
  logic       HSELM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic       HMASTLOCKM;
  logic [1:0] addr_in_port;
  logic       no_port;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

`ifdef AHB_ARB_FIXED_PRIO_EN
  localparam int SECOND_1010 = 1;
`else
  localparam int SECOND_1010 = 3;
`endif

  ahb_out_arb_rr #(.NUM_PORTS(4), .IDX_W(2)) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .req_port     (req_port),
    .HREADYM      (HREADYM),
    .HSELM        (HSELM),
    .HTRANSM      (HTRANSM),
    .HBURSTM      (HBURSTM),
    .HMASTLOCKM   (HMASTLOCKM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] tr, input logic [2:0] bu, input logic lk);
    HTRANSM    = tr;
    HBURSTM    = bu;
    HMASTLOCKM = lk;
  endtask

  task automatic grant_is(input string tag, input int port);
    check_eq({tag, "_port"}, 32'(addr_in_port), 32'(port));
    check_eq({tag, "_noport"}, 32'(no_port), 32'd0);
  endtask

  initial begin
    HRESET = 1'b1; req_port = 4'b0000; HREADYM = 1'b1; HSELM = 1'b1;
    drive(IDLE, 3'b000, 1'b0);
    tick(); tick();
    check_eq("rst_noport", 32'(no_port), 32'd1);
    check_eq("rst_port", 32'(addr_in_port), 32'd0);
    check_eq("rst_cnt", 32'(dut.beat_cnt_q), 32'd0);
    HRESET = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("idle_noport", 32'(no_port), 32'd1);
      check_eq("idle_port", 32'(addr_in_port), 32'd0);
    end

    // All ports requesting SINGLE transfers: grant rotates every beat
    req_port = 4'b1111;
    drive(NSEQ, 3'b000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      grant_is("rr", i % 4);
    end
    tick();
    grant_is("rr_to2", 2);

    // Port 2 INCR8 with a two-cycle wait state after beat 4
    drive(NSEQ, 3'b101, 1'b0);
    tick();
    grant_is("incr8_b1", 2);
    check_eq("incr8_cnt_b1", 32'(dut.beat_cnt_q), 32'd7);
    drive(SEQ, 3'b101, 1'b0);
    for (int b = 2; b <= 4; b++) begin
      tick();
      grant_is("incr8_b", 2);
    end
    HREADYM = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      grant_is("incr8_wait", 2);
      check_eq("incr8_wait_cnt", 32'(dut.beat_cnt_q), 32'd4);
    end
    HREADYM = 1'b1;
    for (int b = 5; b <= 7; b++) begin
      tick();
      grant_is("incr8_b", 2);
    end
    tick();
    grant_is("incr8_end", 3);
    check_eq("incr8_cnt_end", 32'(dut.beat_cnt_q), 32'd0);

    // Locked sequence on port 1
    drive(NSEQ, 3'b000, 1'b0);
    tick();
    grant_is("pre_lock0", 0);
    tick();
    grant_is("pre_lock1", 1);
    drive(NSEQ, 3'b000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      grant_is("lock_single", 1);
    end
    drive(IDLE, 3'b000, 1'b1);
    tick();
    grant_is("lock_idle", 1);
    drive(IDLE, 3'b000, 1'b0);
    tick();
    grant_is("unlock", 2);

    // No requesters: no_port rises, index holds
    req_port = 4'b0000;
    tick();
    check_eq("noreq_noport", 32'(no_port), 32'd1);
    check_eq("noreq_port", 32'(addr_in_port), 32'd2);
    req_port = 4'b0001;
    tick();
    grant_is("only0", 0);

    // Port 0 WRAP4 with BUSY after beat 2
    req_port = 4'b1111;
    drive(NSEQ, 3'b010, 1'b0);
    tick();
    grant_is("wrap4_b1", 0);
    check_eq("wrap4_cnt_b1", 32'(dut.beat_cnt_q), 32'd3);
    drive(SEQ, 3'b010, 1'b0);
    tick();
    check_eq("wrap4_cnt_b2", 32'(dut.beat_cnt_q), 32'd2);
    drive(BUSY, 3'b010, 1'b0);
    tick();
    grant_is("wrap4_busy", 0);
    check_eq("wrap4_cnt_busy", 32'(dut.beat_cnt_q), 32'd2);
    drive(SEQ, 3'b010, 1'b0);
    tick();
    grant_is("wrap4_b3", 0);
    check_eq("wrap4_cnt_b3", 32'(dut.beat_cnt_q), 32'd1);
    tick();
    check_eq("wrap4_cnt_b4", 32'(dut.beat_cnt_q), 32'd0);
    grant_is("wrap4_end", 1);

    // Port 1 INCR4 interrupted by asynchronous reset
    drive(NSEQ, 3'b011, 1'b0);
    tick();
    grant_is("incr4_b1", 1);
    check_eq("incr4_cnt_b1", 32'(dut.beat_cnt_q), 32'd3);
    drive(SEQ, 3'b011, 1'b0);
    tick();
    check_eq("incr4_cnt_b2", 32'(dut.beat_cnt_q), 32'd2);
    #2 HRESET = 1'b1;
    #1;
    check_eq("arst_noport", 32'(no_port), 32'd1);
    check_eq("arst_cnt", 32'(dut.beat_cnt_q), 32'd0);
    check_eq("arst_port", 32'(addr_in_port), 32'd0);
    tick();
    check_eq("arst_hold_noport", 32'(no_port), 32'd1);
    HRESET = 1'b0;

    // Two non-adjacent requesters, then sole-requester re-grant
    req_port = 4'b1010;
    drive(NSEQ, 3'b000, 1'b0);
    tick();
    grant_is("r1010_a", 1);
    tick();
    grant_is("r1010_b", SECOND_1010);
    tick();
    grant_is("r1010_c", 1);
    req_port = 4'b1000;
    tick();
    grant_is("r1000", 3);
    req_port = 4'b0010;
    tick();
    grant_is("sole_a", 1);
    tick();
    grant_is("sole_b", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
